draw_scheduler: RTL



---
 rtl/game_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/draw_scheduler.sv | 107 ++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game-level constants: channel indices, sprite state codes, scheduler FSM states.
package game_pkg;

    localparam int unsigned DEF_STATE_W = 4;

    localparam int unsigned CH_BIRD = 0;
    localparam int unsigned CH_WALL = 1;

    localparam logic [DEF_STATE_W-1:0] SPR_FLAP  = 4'b0001;
    localparam logic [DEF_STATE_W-1:0] SPR_FALL  = 4'b0010;
    localparam logic [DEF_STATE_W-1:0] SPR_WALL  = 4'b0100;
    localparam logic [DEF_STATE_W-1:0] SPR_SCORE = 4'b1000;
    localparam logic [DEF_STATE_W-1:0] SPR_IDLE  = 4'b1111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DRAW = 1'b1
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester searching upward from last_ch+1 (mod NUM_CH).
module rr_arbiter #(
    parameter int unsigned NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [$clog2(NUM_CH)-1:0] last_ch,
    output logic [NUM_CH-1:0]         grant,
    output logic [$clog2(NUM_CH)-1:0] idx,
    output logic                      any
);
    localparam int unsigned CW = $clog2(NUM_CH);

    int unsigned c;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = 0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            c = (32'(last_ch) + k) % NUM_CH;
            if (!any && req[CW'(c)]) begin
                any            = 1'b1;
                grant[CW'(c)]  = 1'b1;
                idx            = CW'(c);
            end
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Round-robin scheduler sharing one VGA draw engine among NUM_CH sprite controllers.
// Optional draw watchdog enabled by defining DRAW_TIMEOUT_EN.
module draw_scheduler
    import game_pkg::*;
#(
    parameter int unsigned         NUM_CH      = 4,
    parameter int unsigned         STATE_W     = DEF_STATE_W,
    parameter logic [STATE_W-1:0]  IDLE_CODE   = STATE_W'(SPR_IDLE),
    parameter int unsigned         TIMEOUT_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH*STATE_W-1:0]   ch_state,
    input  logic [NUM_CH-1:0]           ch_req,
    input  logic                        draw_done,
    input  logic                        freeze,
    output logic [STATE_W-1:0]          cur_state,
    output logic [$clog2(NUM_CH)-1:0]   cur_ch,
    output logic [NUM_CH-1:0]           ch_grant,
    output logic                        busy,
    output logic                        timeout_err
);
    localparam int unsigned CW = $clog2(NUM_CH);

    sched_state_e        state;
    logic [CW-1:0]       last_ch;
    logic [NUM_CH-1:0]   win_oh;
    logic [CW-1:0]       win_idx;
    logic                win_any;
    logic [STATE_W-1:0]  win_state;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req     (ch_req),
        .last_ch (last_ch),
        .grant   (win_oh),
        .idx     (win_idx),
        .any     (win_any)
    );

    // Select the winner's state code with constant slices only.
    always_comb begin
        win_state = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (CW'(i) == win_idx) win_state = ch_state[i*STATE_W +: STATE_W];
        end
    end

`ifdef DRAW_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cur_state <= IDLE_CODE;
            cur_ch    <= '0;
            ch_grant  <= '0;
            busy      <= 1'b0;
            last_ch   <= CW'(NUM_CH - 1);
`ifdef DRAW_TIMEOUT_EN
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            ch_grant <= '0;
`ifdef DRAW_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (!freeze && win_any) begin
                        cur_ch    <= win_idx;
                        cur_state <= win_state;
                        ch_grant  <= win_oh;
                        busy      <= 1'b1;
                        last_ch   <= win_idx;
                        state     <= S_DRAW;
`ifdef DRAW_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                    end
                end
                S_DRAW: begin
                    // Completion has priority over the watchdog on the limit cycle.
                    if (draw_done) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
`ifdef DRAW_TIMEOUT_EN
                    else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
